// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall unit: stall-cause vector layout,
// operand slot numbering and the scoreboard counter width helper.
package hazard_stall_unit_pkg;

    // Default number of external busy sources.
    localparam int STALL_N_BUSY = 2;

    // Bit positions inside the stall-cause vector.
    // Bit 0 is the load hazard, bit k+1 is busy[k].
    localparam int STALL_LOAD      = 0;
    localparam int STALL_BUSY_LSB  = 1;

    // Cause vector for the default busy-source count.
    typedef logic [STALL_N_BUSY:0] stall_cause_t;

    // Operand slots of the decoded instruction.
    localparam int N_OPERANDS = 3;
    localparam int OP_D       = 0;
    localparam int OP_S       = 1;
    localparam int OP_T       = 2;

    // Width of one countdown counter able to hold the load latency.
    function automatic int sb_cnt_width(input int latency);
        int w;
        w = $clog2(latency + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_load_scoreboard.sv
// Per-register load latency scoreboard. Each architectural register owns a
// countdown that is loaded when a load targeting it issues and then counts
// down to zero; a nonzero count means the result is not yet forwardable.
// Three lookup ports (d, s, t) report whether a decoded operand must wait.
module load_scoreboard
    import hazard_stall_unit_pkg::*;
#(
    parameter int LOAD_LATENCY = 1,
    parameter int REG_NUM      = 16,
    parameter int ZERO_REG     = 1,
    parameter int REG_W        = $clog2(REG_NUM)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        dec_valid,
    input  logic [N_OPERANDS-1:0]       dec_src_v,
    input  logic [N_OPERANDS*REG_W-1:0] dec_src_idx,
    input  logic                        load_issue,
    input  logic                        flush,
    output logic                        load_hazard
);

    localparam int              SB_W     = sb_cnt_width(LOAD_LATENCY);
    localparam logic [SB_W-1:0] LAT_VAL  = SB_W'(LOAD_LATENCY);
    localparam logic [SB_W-1:0] ONE      = SB_W'(1);
    localparam bit              SKIP_R0  = (ZERO_REG != 0);

    logic [SB_W-1:0]       cnt_q [REG_NUM];
    logic [SB_W-1:0]       cnt_d [REG_NUM];
    logic [REG_W-1:0]      dst_idx;
    logic [N_OPERANDS-1:0] op_pending;
    logic [N_OPERANDS-1:0] op_hit;

    // The load destination always sits in the d slot.
    assign dst_idx = dec_src_idx[OP_D*REG_W +: REG_W];

    // Counter update: flush clears everything, a fresh load issue reloads the
    // full latency (winning over the decrement), otherwise count down to zero.
    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (load_issue && (dst_idx == REG_W'(r)) &&
                         !(SKIP_R0 && (r == 0))) begin
                cnt_d[r] = LAT_VAL;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - ONE;
            end
        end
    end

    // Counter array state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < REG_NUM; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < REG_NUM; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Operand lookup: compare against every register so that indices beyond
    // REG_NUM (non power-of-two register files) simply never match.
    always_comb begin
        for (int i = 0; i < N_OPERANDS; i++) begin
            op_pending[i] = 1'b0;
            for (int r = 0; r < REG_NUM; r++) begin
                if ((dec_src_idx[i*REG_W +: REG_W] == REG_W'(r)) &&
                    (cnt_q[r] != '0) && !(SKIP_R0 && (r == 0))) begin
                    op_pending[i] = 1'b1;
                end
            end
            op_hit[i] = dec_src_v[i] & op_pending[i];
        end
    end

    // Hazard only when decode actually holds an instruction.
    assign load_hazard = dec_valid & (|op_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// Front-end stall unit. Merges the load hazard from the scoreboard with the
// external busy requests into a cause vector, drives the combinational PC /
// decode hold, a delayed copy for the decode phase, and a saturating count of
// stalled cycles.
//
// Handshake: decode presents an instruction with dec_valid; it is accepted
// (issues) in any cycle where stall_pc is low and flush is low. While
// stall_pc is high the same instruction must be held and re-presented;
// nothing about it is recorded until the cycle it issues.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int LOAD_LATENCY = 1,
    parameter int N_BUSY       = STALL_N_BUSY,
    parameter int REG_NUM      = 16,
    parameter int ZERO_REG     = 1,
    parameter int PHASE_DELAY  = 1,
    parameter int CNT_W        = 16,
    localparam int REG_W       = $clog2(REG_NUM)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        dec_valid,
    input  logic [2:0]                  dec_src_v,
    input  logic [3*REG_W-1:0]          dec_src_idx,
    input  logic                        dec_is_load,
    input  logic                        dec_dst_we,
    input  logic                        flush,
    input  logic [N_BUSY-1:0]           busy,
    input  logic                        cnt_clr,
    output logic                        stall_pc,
    output logic                        stall_phase,
    output logic [N_BUSY:0]             stall_cause,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                   load_hazard;
    logic                   issue;
    logic                   load_issue;
    logic [N_BUSY:0]        cause;
    logic [PHASE_DELAY-1:0] phase_q;
    logic [PHASE_DELAY-1:0] phase_d;
    logic [CNT_W-1:0]       stall_cnt_q;
    logic [CNT_W-1:0]       stall_cnt_d;

    // Only an unstalled, unflushed load that writes its d register is tracked.
    assign issue      = dec_valid & ~stall_pc & ~flush;
    assign load_issue = issue & dec_is_load & dec_dst_we;

    load_scoreboard #(
        .LOAD_LATENCY (LOAD_LATENCY),
        .REG_NUM      (REG_NUM),
        .ZERO_REG     (ZERO_REG),
        .REG_W        (REG_W)
    ) u_load_scoreboard (
        .clk          (clk),
        .rstn         (rstn),
        .dec_valid    (dec_valid),
        .dec_src_v    (dec_src_v),
        .dec_src_idx  (dec_src_idx),
        .load_issue   (load_issue),
        .flush        (flush),
        .load_hazard  (load_hazard)
    );

    // Cause merge: load hazard in the low bit, busy sources above it.
    always_comb begin
        cause                                     = '0;
        cause[STALL_LOAD]                         = load_hazard;
        cause[STALL_BUSY_LSB +: N_BUSY]           = busy;
    end

    assign stall_cause = cause;
    assign stall_pc    = |cause;

    // Delay line for stall_phase; a flush empties it so no stale hold leaks
    // into the refilled pipe.
    always_comb begin
        phase_d    = '0;
        phase_d[0] = stall_pc;
        for (int i = 1; i < PHASE_DELAY; i++) begin
            phase_d[i] = phase_q[i-1];
        end
        if (flush) begin
            phase_d = '0;
        end
    end

    // Delay line state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign stall_phase = phase_q[PHASE_DELAY-1];

    // Stall cycle counter: clear has priority, otherwise count once per
    // stalled cycle regardless of how many causes are active, and stick at
    // all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (stall_pc && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // Stall counter state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit. Two instances share the stimulus: one with
// default parameters, one with LOAD_LATENCY=3, CNT_W=4, PHASE_DELAY=2.
// Only the selected instance is compared; both are reset between phases.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        dec_valid;
  logic [2:0]  dec_src_v;
  logic [11:0] dec_src_idx;
  logic        dec_is_load;
  logic        dec_dst_we;
  logic        flush;
  logic [1:0]  busy;
  logic        cnt_clr;

  logic        pc_a, ph_a, pc_b, ph_b;
  logic [2:0]  cause_a, cause_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  hazard_stall_unit u_dut_a (
    .clk(clk), .rstn(rstn), .dec_valid(dec_valid), .dec_src_v(dec_src_v),
    .dec_src_idx(dec_src_idx), .dec_is_load(dec_is_load), .dec_dst_we(dec_dst_we),
    .flush(flush), .busy(busy), .cnt_clr(cnt_clr), .stall_pc(pc_a),
    .stall_phase(ph_a), .stall_cause(cause_a), .stall_cnt(cnt_a)
  );

  hazard_stall_unit #(.LOAD_LATENCY(3), .CNT_W(4), .PHASE_DELAY(2)) u_dut_b (
    .clk(clk), .rstn(rstn), .dec_valid(dec_valid), .dec_src_v(dec_src_v),
    .dec_src_idx(dec_src_idx), .dec_is_load(dec_is_load), .dec_dst_we(dec_dst_we),
    .flush(flush), .busy(busy), .cnt_clr(cnt_clr), .stall_pc(pc_b),
    .stall_phase(ph_b), .stall_cause(cause_b), .stall_cnt(cnt_b)
  );

  // clock / selection
  always #5 clk = ~clk;

  int          sel = 0;
  logic        o_pc, o_ph;
  logic [2:0]  o_cause;
  logic [15:0] o_cnt;
  assign o_pc    = (sel == 1) ? pc_b : pc_a;
  assign o_ph    = (sel == 1) ? ph_b : ph_a;
  assign o_cause = (sel == 1) ? cause_b : cause_a;
  assign o_cnt   = (sel == 1) ? {12'd0, cnt_b} : cnt_a;

  // scoreboard state
  int          n_vec = 0;
  int          n_err = 0;
  logic [0:0]  exp_q[$];
  logic [15:0] exp_cnt;
  logic [15:0] cnt_max;
  int          phase_delay;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] sv, input logic [3:0] d,
                       input logic [3:0] s, input logic [3:0] t, input logic ld,
                       input logic [1:0] bz, input logic fl, input logic clr);
    dec_valid   = v;
    dec_src_v   = sv;
    dec_src_idx = {t, s, d};
    dec_is_load = ld;
    dec_dst_we  = ld;
    busy        = bz;
    flush       = fl;
    cnt_clr     = clr;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  // One clock: compare outputs mid-cycle, then advance the expected state.
  task automatic step(input logic exp_pc, input logic [2:0] exp_cause);
    @(negedge clk);
    check("stall_pc", {15'd0, o_pc}, {15'd0, exp_pc});
    check("stall_cause", {13'd0, o_cause}, {13'd0, exp_cause});
    check("stall_phase", {15'd0, o_ph}, {15'd0, exp_q[0]});
    check("stall_cnt", o_cnt, exp_cnt);
    void'(exp_q.pop_front());
    exp_q.push_back(exp_pc);
    if (flush) begin
      foreach (exp_q[i]) exp_q[i] = 1'b0;
    end
    if (cnt_clr) exp_cnt = 16'd0;
    else if (exp_pc && exp_cnt != cnt_max) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int s);
    sel = s;
    phase_delay = (s == 1) ? 2 : 1;
    cnt_max = (s == 1) ? 16'h000F : 16'hFFFF;
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall_pc", {15'd0, o_pc}, 16'd0);
    check("rst_cause", {13'd0, o_cause}, 16'd0);
    check("rst_phase", {15'd0, o_ph}, 16'd0);
    check("rst_cnt", o_cnt, 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    for (int i = 0; i < phase_delay; i++) exp_q.push_back(1'b0);
    exp_cnt = 16'd0;
  endtask

  typedef struct {
    logic       v;
    logic [2:0] sv;
    logic [3:0] d, s, t;
    logic       ld;
    logic [1:0] bz;
    logic [2:0] exp_cause;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // table: empty scoreboard, busy merge and blocked-load behaviour
    vecs[0] = '{1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 3'b000};
    vecs[1] = '{1'b1, 3'b111, 4'd1, 4'd2, 4'd3, 1'b0, 2'b00, 3'b000};
    vecs[2] = '{1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'b01, 3'b010};
    vecs[3] = '{1'b1, 3'b110, 4'd0, 4'd4, 4'd5, 1'b0, 2'b10, 3'b100};
    vecs[4] = '{1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'b11, 3'b110};
    vecs[5] = '{1'b1, 3'b001, 4'd3, 4'd0, 4'd0, 1'b1, 2'b01, 3'b010};
    vecs[6] = '{1'b1, 3'b010, 4'd1, 4'd3, 4'd0, 1'b0, 2'b00, 3'b000};
    vecs[7] = '{1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'b10, 3'b100};

    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].v, vecs[i].sv, vecs[i].d, vecs[i].s, vecs[i].t, vecs[i].ld,
            vecs[i].bz, 1'b0, 1'b0);
      step(|vecs[i].exp_cause, vecs[i].exp_cause);
    end

    // load r3 then consumer of r3 in s: one stall cycle, phase follows
    drive(1, 3'b011, 4'd3, 4'd1, 4'd0, 1, 2'b00, 0, 0); step(0, 3'b000);
    drive(1, 3'b010, 4'd2, 4'd3, 4'd0, 0, 2'b00, 0, 0); step(1, 3'b001);
    step(0, 3'b000);
    idle(); step(0, 3'b000);

    // r0 never tracked; r4 hazard seen through the d slot alone
    drive(1, 3'b001, 4'd0, 4'd0, 4'd0, 1, 2'b00, 0, 0); step(0, 3'b000);
    drive(1, 3'b010, 4'd1, 4'd0, 4'd0, 0, 2'b00, 0, 0); step(0, 3'b000);
    drive(1, 3'b001, 4'd4, 4'd0, 4'd0, 1, 2'b00, 0, 0); step(0, 3'b000);
    drive(1, 3'b001, 4'd4, 4'd0, 4'd0, 0, 2'b00, 0, 0); step(1, 3'b001);
    step(0, 3'b000);

    // flush: current-cycle stall still driven, tracked loads killed
    drive(1, 3'b001, 4'd7, 4'd0, 4'd0, 1, 2'b00, 0, 0); step(0, 3'b000);
    drive(1, 3'b010, 4'd1, 4'd7, 4'd0, 0, 2'b00, 1, 0); step(1, 3'b001);
    drive(1, 3'b010, 4'd1, 4'd7, 4'd0, 0, 2'b00, 0, 0); step(0, 3'b000);
    drive(1, 3'b001, 4'd7, 4'd0, 4'd0, 1, 2'b00, 0, 0); step(0, 3'b000);
    drive(0, 3'b000, 4'd0, 4'd0, 4'd0, 0, 2'b00, 1, 0); step(0, 3'b000);
    drive(1, 3'b010, 4'd1, 4'd7, 4'd0, 0, 2'b00, 0, 0); step(0, 3'b000);
    drive(1, 3'b001, 4'd9, 4'd0, 4'd0, 1, 2'b00, 1, 0); step(0, 3'b000);
    drive(1, 3'b010, 4'd1, 4'd9, 4'd0, 0, 2'b00, 0, 0); step(0, 3'b000);

    // busy[1] overlapping a load hazard; dependent load waits, counted once
    drive(1, 3'b001, 4'd5, 4'd0, 4'd0, 1, 2'b00, 0, 1); step(0, 3'b000);
    drive(1, 3'b011, 4'd6, 4'd5, 4'd0, 1, 2'b10, 0, 0); step(1, 3'b101);
    step(1, 3'b100);
    step(1, 3'b100);
    step(1, 3'b100);
    drive(1, 3'b011, 4'd6, 4'd5, 4'd0, 1, 2'b00, 0, 0); step(0, 3'b000);
    drive(1, 3'b010, 4'd1, 4'd6, 4'd0, 0, 2'b00, 0, 0); step(1, 3'b001);
    step(0, 3'b000);
    idle(); step(0, 3'b000);

    // LOAD_LATENCY=3 instance: three stall cycles
    do_reset(1);
    drive(1, 3'b001, 4'd5, 4'd0, 4'd0, 1, 2'b00, 0, 0); step(0, 3'b000);
    drive(1, 3'b100, 4'd1, 4'd2, 4'd5, 0, 2'b00, 0, 0); step(1, 3'b001);
    step(1, 3'b001);
    step(1, 3'b001);
    step(0, 3'b000);
    idle(); step(0, 3'b000);

    // CNT_W=4 saturation, then clear beating a same-cycle stall
    for (int i = 0; i < 20; i++) begin
      drive(0, 3'b000, 4'd0, 4'd0, 4'd0, 0, 2'b01, 0, 0); step(1, 3'b010);
    end
    idle(); step(0, 3'b000);
    drive(0, 3'b000, 4'd0, 4'd0, 4'd0, 0, 2'b01, 0, 1); step(1, 3'b010);
    idle(); step(0, 3'b000);

    // asynchronous reset in the middle of a hazard
    drive(1, 3'b001, 4'd8, 4'd0, 4'd0, 1, 2'b00, 0, 0); step(0, 3'b000);
    drive(1, 3'b010, 4'd1, 4'd8, 4'd0, 0, 2'b00, 0, 0); step(1, 3'b001);
    busy = 2'b10;
    #1;
    rstn = 1'b0;
    #1;
    check("async_rst_pc_busy", {15'd0, o_pc}, 16'd1);
    check("async_rst_cause", {13'd0, o_cause}, 16'h0004);
    check("async_rst_phase", {15'd0, o_ph}, 16'd0);
    check("async_rst_cnt", o_cnt, 16'd0);
    busy = 2'b00;
    #1;
    check("async_rst_no_hazard", {15'd0, o_pc}, 16'd0);
    do_reset(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Parametrised successor to the front-end stall logic: tracks in-flight loads in a per-register latency scoreboard and stalls the PC/decode stage until every source and destination of the decoded instruction is forwardable. It also merges N external busy sources, classifies each stall cycle by cause, and counts stall cycles. It sits between decode and the post-decode pipe, beside the forwarding controller; its `stall_pc`/`stall_phase` outputs drive the fetch and decode enables.

## Interface
- `LOAD_LATENCY`, 1: cycles (≥1) from load issue until its result can be forwarded.
- `N_BUSY`, 2: number of external busy sources, e.g. out, in (≥1).
- `REG_NUM`, 16: architectural register count; `REG_W = $clog2(REG_NUM)`.
- `ZERO_REG`, 1: if 1, register index 0 is hard-wired and never tracked.
- `PHASE_DELAY`, 1: cycles by which `stall_phase` lags `stall_pc` (≥1).
- `CNT_W`, 16: stall-counter width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `dec_valid`  in  1  decode slot holds an instruction.
- `dec_src_v`  in  3  valid bits for operands d, s, t.
- `dec_src_idx`  in  3×REG_W  register indices for d, s, t.
- `dec_is_load`  in  1  decoded instruction is a load (MIOP_L).
- `dec_dst_we`  in  1  decoded instruction writes `dec_src_idx[0]` (d).
- `flush`  in  1  pipeline flush; kills tracked loads.
- `busy`  in  N_BUSY  external busy requests.
- `cnt_clr`  in  1  synchronous clear of `stall_cnt`.
- `stall_pc`  out  1  hold PC/decode this cycle (combinational).
- `stall_phase`  out  1  `stall_pc` delayed PHASE_DELAY cycles.
- `stall_cause`  out  N_BUSY+1  bit 0 = load hazard, bit k+1 = `busy[k]`.
- `stall_cnt`  out  CNT_W  saturating count of stalled cycles.

## Operation
- Scoreboard: one countdown `cnt[r]` per register, width `$clog2(LOAD_LATENCY+1)`.
- Issue: `issue = dec_valid & ~stall_pc & ~flush`.
- Load issue (`issue & dec_is_load & dec_dst_we`, index ≠0 when ZERO_REG): `cnt[dst] <= LOAD_LATENCY`.
- Every other nonzero counter decrements by 1 each cycle; zero holds.
- Same-register issue while its counter is nonzero: reload to LOAD_LATENCY. The new issue wins over the decrement.
- Load hazard: `dec_valid & OR over i of (dec_src_v[i] & cnt[dec_src_idx[i]] != 0)`. Index 0 is ignored when ZERO_REG.
- `stall_cause = {busy, load_hazard}`; `stall_pc = |stall_cause`.
- A load blocked by any stall is not recorded; it is re-presented next cycle.
- `flush`: all counters ← 0 next cycle and shift register cleared. Flush beats a same-cycle load issue. Combinational `stall_pc` is still driven from the current state in that cycle.
- `stall_cnt` increments when `stall_pc`, saturating at all-ones. `cnt_clr` has priority and loads 0.

## Timing
- Reset: all counters 0, `stall_phase` 0, `stall_cnt` 0. `stall_pc`/`stall_cause` are then driven only by `busy`/`dec_valid`.
- Load issued at cycle t: a dependent instruction in decode stalls cycles t+1 … t+LOAD_LATENCY and issues at t+LOAD_LATENCY+1.
- `busy[k]` → `stall_pc` with zero-cycle latency.
- `stall_phase(t) = stall_pc(t−PHASE_DELAY)`, implemented as a shift register.
- Reset mid-operation clears all state immediately (async). No pending hazards survive reset.
- Simultaneous load hazard and busy: both cause bits set, `stall_cnt` +1 only.

## Structure
- Shared package: `STALL_LOAD` cause index and the cause-vector typedef, parameterised by N_BUSY via localparam.
- Sub-module `load_scoreboard`: counter array, issue/flush/decrement, and hazard lookup for three read ports.
- Top level: cause merge, delay shift register, stall counter.

## Test plan
- Defaults: load r3 at t=10, then `add` reading r3 (s) at t=11 → `stall_pc` 1 at t=11 only, issue at t=12, `stall_phase` 1 at t=12.
- LOAD_LATENCY=3, load r5 then consumer → stall t+1..t+3, `stall_cnt`=3, `stall_cause`=3'b001 each cycle.
- Load r0 with ZERO_REG=1, consumer reads r0 → no stall. Consumer uses r4 via d only (`dec_src_v`=3'b001) after load r4 → stall.
- `flush` in the cycle after load r7 issues → dependent instruction next cycle not stalled. Load issued together with flush is not recorded.
- `busy`=2'b10 for 4 cycles during a load hazard → `stall_cause`=3'b101 while overlapping; load waits; `stall_cnt` counts 4, not 5.
- CNT_W=4: hold `busy[0]` 20 cycles → `stall_cnt` saturates at 15. `cnt_clr` asserted together with a stall → 0. Assert `rstn`=0 mid-hazard → all outputs at reset values asynchronously.
